// File: rtl/clause_array_loader.sv
// Clause array load/unload controller: streams clauses into one-hot cells,
// zero-fills unused slots, and reads cells back onto a valid/ready stream.
module clause_array_loader #(
  parameter int NUM_VARS    = 8,
  parameter int NUM_CLAUSES = 8,
  parameter int WIDTH_C_LEN = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_load_i,
  input  logic                             start_unload_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             overflow_o,
  input  logic                             load_valid_i,
  output logic                             load_ready_o,
  input  logic [NUM_VARS*2-1:0]            load_clause_i,
  input  logic                             load_last_i,
  output logic [NUM_CLAUSES-1:0]           wr_o,
  output logic [NUM_CLAUSES-1:0]           rd_o,
  output logic [NUM_VARS*2-1:0]            clause_o,
  output logic [WIDTH_C_LEN-1:0]           clause_len_o,
  input  logic [NUM_VARS*2-1:0]            clause_i,
  input  logic [WIDTH_C_LEN*NUM_CLAUSES-1:0] clause_len_i,
  output logic                             unload_valid_o,
  input  logic                             unload_ready_i,
  output logic [NUM_VARS*2-1:0]            unload_clause_o,
  output logic [WIDTH_C_LEN-1:0]           unload_len_o,
  output logic                             unload_last_o
);

  localparam int CW = NUM_VARS * 2;
  localparam int IW = (NUM_CLAUSES > 1) ? $clog2(NUM_CLAUSES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_CLAUSES - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, FILL, RD, OUT, DONE
  } state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [NUM_CLAUSES-1:0] wr_q, wr_d;
  logic [CW-1:0]        clause_q, clause_d;
  logic [WIDTH_C_LEN-1:0] len_q, len_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q, done_d;
  logic                 unl_q, unl_d;
  logic [CW-1:0]        uclause_q, uclause_d;
  logic [WIDTH_C_LEN-1:0] ulen_q, ulen_d;

  logic                 last_slot;
  logic [NUM_CLAUSES-1:0] sel;

  function automatic logic [WIDTH_C_LEN-1:0] count_lits(
    input logic [CW-1:0] c
  );
    logic [WIDTH_C_LEN-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_VARS; i++) begin
      n = n + WIDTH_C_LEN'(|c[2*i +: 2]);
    end
    return n;
  endfunction

  assign last_slot = (idx_q == LAST);
  assign sel       = NUM_CLAUSES'(1) << idx_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wr_d      = '0;
    clause_d  = '0;
    len_d     = '0;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    unl_d     = unl_q;
    uclause_d = uclause_q;
    ulen_d    = ulen_q;
    unique case (state_q)
      IDLE: begin
        if (start_load_i) begin
          state_d = LOAD;
          idx_d   = '0;
          ovf_d   = 1'b0;
          unl_d   = 1'b0;
        end else if (start_unload_i) begin
          state_d = RD;
          idx_d   = '0;
          unl_d   = 1'b1;
        end
      end
      LOAD: begin
        if (load_valid_i) begin
          wr_d     = sel;
          clause_d = load_clause_i;
          len_d    = count_lits(load_clause_i);
          if (last_slot) begin
            state_d = DONE;
            ovf_d   = ovf_q | ~load_last_i;
          end else if (load_last_i) begin
            state_d = FILL;
            idx_d   = idx_q + 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      FILL: begin
        wr_d = sel;
        if (last_slot) state_d = DONE;
        else idx_d = idx_q + 1'b1;
      end
      RD: begin
        uclause_d = clause_i;
        ulen_d    = clause_len_i[int'(idx_q)*WIDTH_C_LEN +: WIDTH_C_LEN];
        state_d   = OUT;
      end
      OUT: begin
        if (unload_ready_i) begin
          if (last_slot) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = RD;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        // load passes pulse done after the final write is visible
        done_d  = ~unl_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      wr_q      <= '0;
      clause_q  <= '0;
      len_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      unl_q     <= 1'b0;
      uclause_q <= '0;
      ulen_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wr_q      <= wr_d;
      clause_q  <= clause_d;
      len_q     <= len_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      unl_q     <= unl_d;
      uclause_q <= uclause_d;
      ulen_q    <= ulen_d;
    end
  end

  assign busy_o          = (state_q != IDLE);
  assign done_o          = done_q;
  assign overflow_o      = ovf_q;
  assign load_ready_o    = (state_q == LOAD);
  assign wr_o            = wr_q;
  assign rd_o            = (state_q == RD) ? sel : '0;
  assign clause_o        = clause_q;
  assign clause_len_o    = len_q;
  assign unload_valid_o  = (state_q == OUT);
  assign unload_clause_o = uclause_q;
  assign unload_len_o    = ulen_q;
  assign unload_last_o   = (state_q == OUT) && last_slot;

endmodule

// File: tb/tb_clause_array_loader.sv
// Directed bench for clause_array_loader: load, fill, overflow, unload
// with stalls, reset mid-pass and handshake gaps.
module tb_clause_array_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_load, start_unload;
  logic        busy, done, overflow;
  logic        load_valid, load_ready;
  logic [15:0] load_clause;
  logic        load_last;
  logic [7:0]  wr, rd;
  logic [15:0] clause_o;
  logic [3:0]  clause_len_o;
  logic [15:0] clause_i;
  logic [31:0] clause_len_i;
  logic        unload_valid, unload_ready;
  logic [15:0] unload_clause;
  logic [3:0]  unload_len;
  logic        unload_last;

  logic [15:0] mem  [8];
  logic [3:0]  lens [8];
  int          gaps [3] = '{1, 3, 2};
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  clause_array_loader dut (
    .clk             (clk),
    .rst             (rst),
    .start_load_i    (start_load),
    .start_unload_i  (start_unload),
    .busy_o          (busy),
    .done_o          (done),
    .overflow_o      (overflow),
    .load_valid_i    (load_valid),
    .load_ready_o    (load_ready),
    .load_clause_i   (load_clause),
    .load_last_i     (load_last),
    .wr_o            (wr),
    .rd_o            (rd),
    .clause_o        (clause_o),
    .clause_len_o    (clause_len_o),
    .clause_i        (clause_i),
    .clause_len_i    (clause_len_i),
    .unload_valid_o  (unload_valid),
    .unload_ready_i  (unload_ready),
    .unload_clause_o (unload_clause),
    .unload_len_o    (unload_len),
    .unload_last_o   (unload_last)
  );

  // model of the cell array read side
  always_comb begin
    clause_i     = '0;
    clause_len_i = '0;
    for (int k = 0; k < 8; k++) begin
      if (rd[k]) clause_i = clause_i | mem[k];
      clause_len_i[k*4 +: 4] = lens[k];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("wr_rd_excl", 32'(|(wr & rd)), 32'd0);
      chk("wr_onehot0", 32'($onehot0(wr)), 32'd1);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_wr"}, 32'(wr), 32'd0);
    chk({tag, "_rd"}, 32'(rd), 32'd0);
    chk({tag, "_clause"}, 32'(clause_o), 32'd0);
    chk({tag, "_len"}, 32'(clause_len_o), 32'd0);
    chk({tag, "_ready"}, 32'(load_ready), 32'd0);
    chk({tag, "_valid"}, 32'(unload_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    logic [15:0] hc;
    logic [3:0]  hl;
    logic        hlast;
    int          n;
    int          stall;

    rst = 1'b1;
    start_load = 0; start_unload = 0;
    load_valid = 0; load_clause = '0; load_last = 0;
    unload_ready = 0;
    for (int k = 0; k < 8; k++) begin
      mem[k]  = 16'h1357 + 16'(k) * 16'h0111;
      lens[k] = 4'(k + 1);
    end
    lens[2] = 4'd0;
    step(); step();
    chk_zero("reset");
    rst = 1'b0;

    // both starts together: load wins
    start_load = 1; start_unload = 1;
    step();
    start_load = 0;
    chk("l3_busy", 32'(busy), 32'd1);
    chk("l3_ready", 32'(load_ready), 32'd1);
    chk("l3_rd", 32'(rd), 32'd0);
    load_valid = 1; load_clause = 16'h0009;
    step();
    chk("l3_wr0", 32'(wr), 32'h01);
    chk("l3_clause0", 32'(clause_o), 32'h0009);
    chk("l3_len0", 32'(clause_len_o), 32'd2);
    load_clause = 16'h5555;
    step();
    start_unload = 0;
    chk("l3_wr1", 32'(wr), 32'h02);
    chk("l3_len1", 32'(clause_len_o), 32'd8);
    load_clause = 16'hC000; load_last = 1;
    step();
    load_valid = 0; load_last = 0;
    chk("l3_wr2", 32'(wr), 32'h04);
    chk("l3_clause2", 32'(clause_o), 32'hC000);
    chk("l3_len2", 32'(clause_len_o), 32'd1);
    for (int s = 3; s < 8; s++) begin
      step();
      chk("fill_wr", 32'(wr), 32'(8'h01 << s));
      chk("fill_clause", 32'(clause_o), 32'd0);
      chk("fill_len", 32'(clause_len_o), 32'd0);
      chk("fill_done", 32'(done), 32'd0);
    end
    step();
    chk("l3_done", 32'(done), 32'd1);
    chk("l3_done_wr", 32'(wr), 32'd0);
    chk("l3_ovf", 32'(overflow), 32'd0);
    chk("l3_busy_end", 32'(busy), 32'd0);
    step();
    chk("l3_done_pulse", 32'(done), 32'd0);
    chk("l3_no_unload", 32'(rd), 32'd0);

    // eight beats without last: overflow
    start_load = 1;
    step();
    start_load = 0;
    load_valid = 1;
    for (int k = 0; k < 8; k++) begin
      load_clause = 16'(1) << (2 * k);
      step();
      chk("ovf_wr", 32'(wr), 32'(8'h01 << k));
      chk("ovf_len", 32'(clause_len_o), 32'd1);
      if (k < 7) chk("ovf_ready", 32'(load_ready), 32'd1);
    end
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_ready_end", 32'(load_ready), 32'd0);
    step();
    chk("ovf_done", 32'(done), 32'd1);
    chk("ovf_wr_end", 32'(wr), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    step();
    chk("ovf_no_beat9", 32'(wr), 32'd0);
    load_valid = 0;

    // unload with random stalls
    start_unload = 1;
    step();
    start_unload = 0;
    for (int b = 0; b < 8; b++) begin
      n = 0;
      while (!unload_valid && n < 5) begin
        chk("ul_rd", 32'(rd), 32'(8'h01 << b));
        step();
        n++;
      end
      chk("ul_valid_to", 32'(unload_valid), 32'd1);
      chk("ul_rd_wait", 32'(n), 32'd1);
      chk("ul_clause", 32'(unload_clause), 32'(mem[b]));
      chk("ul_len", 32'(unload_len), 32'(lens[b]));
      chk("ul_last", 32'(unload_last), 32'(b == 7));
      hc = unload_clause; hl = unload_len; hlast = unload_last;
      stall = $urandom_range(0, 2);
      for (int s = 0; s < stall; s++) begin
        step();
        chk("ul_hold_v", 32'(unload_valid), 32'd1);
        chk("ul_hold_c", 32'(unload_clause), 32'(hc));
        chk("ul_hold_l", 32'(unload_len), 32'(hl));
        chk("ul_hold_last", 32'(unload_last), 32'(hlast));
      end
      unload_ready = 1;
      step();
      unload_ready = 0;
    end
    chk("ul_done", 32'(done), 32'd1);
    step();
    chk("ul_done_pulse", 32'(done), 32'd0);
    chk("ul_idle", 32'(busy), 32'd0);

    // reset mid-load
    start_load = 1;
    step();
    start_load = 0;
    chk("rst_ovf_clr", 32'(overflow), 32'd0);
    load_valid = 1; load_clause = 16'h0009;
    step();
    chk("rst_wr0", 32'(wr), 32'h01);
    step();
    chk("rst_wr1", 32'(wr), 32'h02);
    rst = 1;
    step();
    chk_zero("rst_mid");
    rst = 0;
    step();
    chk("rst_after_wr", 32'(wr), 32'd0);
    chk("rst_after_busy", 32'(busy), 32'd0);
    load_valid = 0;

    // handshake gaps
    start_load = 1;
    step();
    start_load = 0;
    for (int b = 0; b < 4; b++) begin
      load_valid = 1; load_clause = 16'h000F; load_last = (b == 3);
      step();
      load_valid = 0; load_last = 0;
      chk("gap_wr", 32'(wr), 32'(8'h01 << b));
      chk("gap_len", 32'(clause_len_o), 32'd2);
      if (b < 3) begin
        for (int g = 0; g < gaps[b]; g++) begin
          step();
          chk("gap_idle_wr", 32'(wr), 32'd0);
          chk("gap_ready", 32'(load_ready), 32'd1);
        end
      end
    end
    for (int s = 4; s < 8; s++) begin
      step();
      chk("gap_fill_wr", 32'(wr), 32'(8'h01 << s));
    end
    step();
    chk("gap_done", 32'(done), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
